// File: rtl/divider_pkg.sv
// Shared types and defaults for the non-restoring divider.
// Holds the FSM state encoding and the default operand width.
package divider_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREPARE,
    ST_DIVIDE,
    ST_RESTORE,
    ST_VALID
  } div_state_t;

endpackage

// File: rtl/non_restoring_divider.sv
// Iterative non-restoring divider; result DATA_WIDTH+3 enabled cycles after capture (2 for /0).
// No backpressure: operands are taken only in IDLE, clk_en_i low freezes everything.
module non_restoring_divider
  import divider_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SIGNED_MODE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clk_en_i,
  input  logic                  valid_entry_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  data_valid_o,
  output logic                  busy_o,
  output logic                  divide_by_zero_o
);

  localparam int W   = DATA_WIDTH;
  localparam int CW  = (W > 1) ? $clog2(W) : 1;
  localparam bit SGN = (SIGNED_MODE != 0);

  div_state_t     state_q, state_d;
  logic [W-1:0]   dividend_q;
  logic [W-1:0]   divisor_q;   // raw on capture, magnitude after PREPARE
  logic [W-1:0]   quo_q;       // |dividend| shifting out, quotient shifting in
  logic [W:0]     prem_q;
  logic [W-1:0]   rem_q;
  logic [CW-1:0]  cnt_q;
  logic           q_neg_q;
  logic           r_neg_q;
  logic           dbz_q;

  logic           dvd_neg, dvs_neg, dvs_zero;
  logic [W-1:0]   dvd_abs, dvs_abs;
  logic [W:0]     prem_shift, prem_next;
  logic [W-1:0]   rem_fix, q_signed, r_signed;

  assign dvd_neg  = SGN && dividend_q[W-1];
  assign dvs_neg  = SGN && divisor_q[W-1];
  assign dvd_abs  = dvd_neg ? (~dividend_q + 1'b1) : dividend_q;
  assign dvs_abs  = dvs_neg ? (~divisor_q + 1'b1) : divisor_q;
  assign dvs_zero = (divisor_q == '0);

  // Partial remainder wraps modulo 2^(W+1); the add/sub always lands back in range.
  assign prem_shift = {prem_q[W-1:0], quo_q[W-1]};
  assign prem_next  = prem_q[W] ? (prem_shift + {1'b0, divisor_q})
                                : (prem_shift - {1'b0, divisor_q});

  assign rem_fix  = prem_q[W] ? (prem_q[W-1:0] + divisor_q) : prem_q[W-1:0];
  assign q_signed = q_neg_q ? (~quo_q + 1'b1) : quo_q;
  assign r_signed = r_neg_q ? (~rem_fix + 1'b1) : rem_fix;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clk_en_i) begin
      case (state_q)
        ST_IDLE:    if (valid_entry_i) state_d = ST_PREPARE;
        ST_PREPARE: state_d = dvs_zero ? ST_VALID : ST_DIVIDE;
        ST_DIVIDE:  if (cnt_q == CW'(W - 1)) state_d = ST_RESTORE;
        ST_RESTORE: state_d = ST_VALID;
        ST_VALID:   state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dividend_q       <= '0;
      divisor_q        <= '0;
      quo_q            <= '0;
      prem_q           <= '0;
      rem_q            <= '0;
      cnt_q            <= '0;
      q_neg_q          <= 1'b0;
      r_neg_q          <= 1'b0;
      dbz_q            <= 1'b0;
      quotient_o       <= '0;
      remainder_o      <= '0;
      data_valid_o     <= 1'b0;
      busy_o           <= 1'b0;
      divide_by_zero_o <= 1'b0;
    end else if (clk_en_i) begin
      data_valid_o     <= 1'b0;
      divide_by_zero_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_entry_i) begin
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
            busy_o     <= 1'b1;
          end
        end
        ST_PREPARE: begin
          q_neg_q <= dvd_neg ^ dvs_neg;
          r_neg_q <= dvd_neg;
          dbz_q   <= dvs_zero;
          prem_q  <= '0;
          cnt_q   <= '0;
          if (dvs_zero) begin
            quo_q <= '1;
            rem_q <= dividend_q;
          end else begin
            quo_q     <= dvd_abs;
            divisor_q <= dvs_abs;
          end
        end
        ST_DIVIDE: begin
          prem_q <= prem_next;
          quo_q  <= {quo_q[W-2:0], ~prem_next[W]};
          cnt_q  <= cnt_q + 1'b1;
        end
        ST_RESTORE: begin
          quo_q <= q_signed;
          rem_q <= r_signed;
        end
        ST_VALID: begin
          quotient_o       <= quo_q;
          remainder_o      <= rem_q;
          data_valid_o     <= 1'b1;
          divide_by_zero_o <= dbz_q;
          busy_o           <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_non_restoring_divider.sv
// Self-checking bench: directed table, reset/stall sequences, random ops vs arithmetic model.
module tb_non_restoring_divider;
  import divider_pkg::*;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_n_i, clk_en_i, valid_entry_i;
  logic [W-1:0] dividend_i, divisor_i, quotient_o, remainder_o;
  logic         data_valid_o, busy_o, divide_by_zero_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  non_restoring_divider #(.DATA_WIDTH(W), .SIGNED_MODE(1)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .clk_en_i         (clk_en_i),
    .valid_entry_i    (valid_entry_i),
    .dividend_i       (dividend_i),
    .divisor_i        (divisor_i),
    .quotient_o       (quotient_o),
    .remainder_o      (remainder_o),
    .data_valid_o     (data_valid_o),
    .busy_o           (busy_o),
    .divide_by_zero_o (divide_by_zero_o)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Signed division straight from the arithmetic rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output int lat);
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1; lat = 2;
    end else begin
      dz = 1'b0; lat = W + 3;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end
  endfunction

  // Issues one op; returns result, edges to data_valid_o, edges to busy_o low.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall_at, input int stall_len,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output int lat, output int bfall);
    dividend_i    = a;
    divisor_i     = b;
    valid_entry_i = 1'b1;
    @(posedge clk_i); #1;
    valid_entry_i = 1'b0;
    lat = -1; bfall = -1; q = 'x; r = 'x; dz = 1'bx;
    for (int c = 1; c <= 200; c++) begin
      if (stall_at > 0 && c == stall_at) clk_en_i = 1'b0;
      if (stall_at > 0 && c == stall_at + stall_len) clk_en_i = 1'b1;
      @(posedge clk_i); #1;
      if (bfall < 0 && !busy_o) bfall = c;
      if (data_valid_o) begin
        lat = c; q = quotient_o; r = remainder_o; dz = divide_by_zero_o;
        break;
      end
    end
    clk_en_i = 1'b1;
  endtask

  initial begin
    logic [W-1:0] q, r, eq, er, a, b;
    logic         dz, edz;
    int           lat, bfall, elat, st, len, sel, dv_seen;

    vecs[0] = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 35};
    vecs[1] = '{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 35};
    vecs[2] = '{32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0, 35};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 35};
    vecs[4] = '{32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2};
    vecs[5] = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 35};
    vecs[6] = '{32'd7,         32'd100,       32'd0,         32'd7,         1'b0, 35};
    vecs[7] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 35};
    vecs[8] = '{32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 2};
    vecs[9] = '{32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 32'd0,         1'b0, 35};

    rst_n_i = 1'b0; clk_en_i = 1'b1; valid_entry_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    #12;
    chk("reset_outputs", {quotient_o, remainder_o}, 64'd0);
    chk("reset_flags", {61'd0, data_valid_o, busy_o, divide_by_zero_o}, 64'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, 0, q, r, dz, lat, bfall);
      chk($sformatf("vec%0d_q", i), 64'(q), 64'(vecs[i].q));
      chk($sformatf("vec%0d_r", i), 64'(r), 64'(vecs[i].r));
      chk($sformatf("vec%0d_dz", i), 64'(dz), 64'(vecs[i].dz));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_fall", i), 64'(bfall), 64'(vecs[i].lat));
      @(posedge clk_i); #1;
      chk($sformatf("vec%0d_dv_pulse", i), 64'(data_valid_o), 64'd0);
    end

    repeat (3) @(posedge clk_i);
    #1;
    chk("hold_quotient", 64'(quotient_o), 64'(vecs[9].q));

    // Reset at cycle 10 of 100/7 aborts the op with no result pulse.
    dividend_i = 32'd100; divisor_i = 32'd7; valid_entry_i = 1'b1;
    @(posedge clk_i); #1;
    valid_entry_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    chk("busy_before_abort", 64'(busy_o), 64'd1);
    rst_n_i = 1'b0;
    #1;
    chk("abort_outputs", {quotient_o, remainder_o}, 64'd0);
    chk("abort_flags", {61'd0, data_valid_o, busy_o, divide_by_zero_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    dv_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      if (data_valid_o || busy_o) dv_seen++;
    end
    chk("abort_no_pulse", 64'(dv_seen), 64'd0);
    run_op(32'd9, 32'd3, 0, 0, q, r, dz, lat, bfall);
    chk("after_abort_q", 64'(q), 64'd3);
    chk("after_abort_r", 64'(r), 64'd0);
    chk("after_abort_lat", 64'(lat), 64'd35);

    // Five stalled edges mid-DIVIDE push the result to cycle 40.
    run_op(32'd100, 32'd7, 12, 5, q, r, dz, lat, bfall);
    chk("stall_q", 64'(q), 64'd14);
    chk("stall_r", 64'(r), 64'd2);
    chk("stall_lat", 64'(lat), 64'd40);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      a = $urandom;
      case (sel)
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom; end
        4: begin a = $urandom_range(0, 50); b = $urandom_range(1, 60); end
        default: b = $urandom;
      endcase
      st  = $urandom_range(0, 40);
      len = $urandom_range(1, 4);
      model(a, b, eq, er, edz, elat);
      if (st >= 1 && st <= elat) elat += len;
      run_op(a, b, st, len, q, r, dz, lat, bfall);
      chk($sformatf("rnd%0d_q a=%h b=%h", i, a, b), 64'(q), 64'(eq));
      chk($sformatf("rnd%0d_r", i), 64'(r), 64'(er));
      chk($sformatf("rnd%0d_dz", i), 64'(dz), 64'(edz));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(elat));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
